cache_bus_responder: RTL and testbench

CACHE_BUS_RESPONDER -- requirements
Module: cache_bus_responder

---
 rtl/cache_bus_responder.sv | 189 ++++++++++++++++++
 tb/tb_cache_bus_responder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_bus_responder.sv
// Cache bus responder: services one read or write burst at a time from a word RAM.
// Latency: first read beat LATENCY+1 cycles after the address handshake, then one beat per cycle.
// Backpressure: a read beat is held until req.data_ok; writes are always accepted; ready only in IDLE.
// Optional protocol checker on err_o is enabled by defining CACHE_BUS_RESP_CHECK_EN.

package cache_bus_pkg;
  typedef struct packed {
    logic        valid;
    logic        write;
    logic [3:0]  burst_size;
    logic        cached;
    logic [1:0]  data_size;
    logic [31:0] addr;
    logic        data_ok;
    logic        data_last;
    logic [3:0]  data_strobe;
    logic [31:0] w_data;
  } cache_bus_req_t;

  typedef struct packed {
    logic        ready;
    logic        data_ok;
    logic [31:0] r_data;
  } cache_bus_resp_t;
endpackage

module cache_bus_responder
  import cache_bus_pkg::*;
#(
  parameter int MEM_WORDS = 4096,  // power of two
  parameter int LATENCY   = 2      // 0..15 idle cycles before the first read beat
) (
  input  logic            clk,
  input  logic            rst,
  input  cache_bus_req_t  bus_req_i,
  output cache_bus_resp_t bus_resp_o,
  output logic            err_o
);

  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    RWAIT = 4'b0010,
    RDATA = 4'b0100,
    WDATA = 4'b1000
  } state_t;

  state_t        state;
  logic [AW-1:0] base;       // word index of beat 0
  logic [3:0]    beat;       // current beat number
  logic [3:0]    last_beat;  // burst_size latched at handshake
  logic [3:0]    lat_cnt;    // remaining RWAIT cycles minus one
  logic          ready;
  logic          data_ok;
  logic [31:0]   r_data;

  logic [31:0]   mem [MEM_WORDS];

  logic [AW-1:0] cur_idx;
  logic [AW-1:0] nxt_idx;
  logic [AW-1:0] req_idx;
  logic          is_last;
  logic          wr_fire;

  // Addresses wrap modulo the RAM depth; no line-boundary wrapping.
  assign cur_idx = base + AW'(beat);
  assign nxt_idx = cur_idx + AW'(1);
  assign req_idx = bus_req_i.addr[AW+1:2];
  assign is_last = (beat == last_beat);
  assign wr_fire = (state == WDATA) && bus_req_i.data_ok;

  assign bus_resp_o.ready   = ready;
  assign bus_resp_o.data_ok = data_ok;
  assign bus_resp_o.r_data  = r_data;

  // Transaction FSM; r_data is reloaded from RAM whenever a new read beat is presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ready     <= 1'b1;
      data_ok   <= 1'b0;
      r_data    <= '0;
      base      <= '0;
      beat      <= '0;
      last_beat <= '0;
      lat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus_req_i.valid) begin
            base      <= req_idx;
            last_beat <= bus_req_i.burst_size;
            beat      <= '0;
            ready     <= 1'b0;
            if (bus_req_i.write) begin
              state   <= WDATA;
              data_ok <= 1'b1;
            end else if (LATENCY == 0) begin
              state   <= RDATA;
              data_ok <= 1'b1;
              r_data  <= mem[req_idx];
            end else begin
              state   <= RWAIT;
              lat_cnt <= 4'(LATENCY - 1);
            end
          end
        end
        RWAIT: begin
          if (lat_cnt == 4'd0) begin
            state   <= RDATA;
            data_ok <= 1'b1;
            r_data  <= mem[cur_idx];
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        RDATA: begin
          if (bus_req_i.data_ok) begin
            if (is_last) begin
              state   <= IDLE;
              ready   <= 1'b1;
              data_ok <= 1'b0;
              r_data  <= '0;
              beat    <= '0;
            end else begin
              beat    <= beat + 4'd1;
              r_data  <= mem[nxt_idx];
            end
          end
        end
        WDATA: begin
          // data_last is not trusted; the beat count alone ends the burst.
          if (bus_req_i.data_ok) begin
            if (is_last) begin
              state   <= IDLE;
              ready   <= 1'b1;
              data_ok <= 1'b0;
              beat    <= '0;
            end else begin
              beat    <= beat + 4'd1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          ready   <= 1'b1;
          data_ok <= 1'b0;
          r_data  <= '0;
          beat    <= '0;
        end
      endcase
    end
  end

  // Byte-lane write into the RAM; reset holds the FSM in IDLE so no write can fire.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < 4; i++) begin
        if (bus_req_i.data_strobe[i]) begin
          mem[cur_idx][8*i +: 8] <= bus_req_i.w_data[8*i +: 8];
        end
      end
    end
  end

  // Fields the responder deliberately ignores.
  logic unused_req;
  assign unused_req = ^{bus_req_i.cached, bus_req_i.data_size, bus_req_i.addr, bus_req_i.data_last};

`ifdef CACHE_BUS_RESP_CHECK_EN
  logic err;

  // Sticky flag: data_last disagreeing with the beat count, or data_ok with no data phase open.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((wr_fire && (bus_req_i.data_last != is_last)) ||
                 (bus_req_i.data_ok && ((state == IDLE) || (state == RWAIT)))) begin
      err <= 1'b1;
    end
  end

  assign err_o = err;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_cache_bus_responder.sv
// Self-checking bench for cache_bus_responder: bursts, stalls, strobes, wrap, reset abort, checker.
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected read words come from a shadow memory and are queued per read burst.
`timescale 1ns/1ps
module tb_cache_bus_responder;
  import cache_bus_pkg::*;

  localparam int MEM_WORDS = 4096;
  localparam int LATENCY   = 2;

  logic            clk = 1'b0;
  logic            rst;
  cache_bus_req_t  req;
  cache_bus_resp_t resp;
  logic            err;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [int];
  logic [31:0] exp_q [$];
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  cache_bus_responder #(.MEM_WORDS(MEM_WORDS), .LATENCY(LATENCY)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_req_i (req),
    .bus_resp_o(resp),
    .err_o     (err)
  );

  function automatic int widx(input logic [31:0] a, input int k);
    return int'((32'(a[31:2]) + 32'(k)) & 32'(MEM_WORDS - 1));
  endfunction

  function automatic void model_write(input int i, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    w = model.exists(i) ? model[i] : 32'hx;
    for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    model[i] = w;
  endfunction

  task automatic handshake(input logic wr, input logic [31:0] a, input logic [3:0] bs);
    int n = 0;
    req.valid = 1'b1; req.write = wr; req.addr = a; req.burst_size = bs;
    while (resp.ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL handshake_timeout ready=%b want 1", resp.ready);
    end
    @(negedge clk);
    req.valid = 1'b0;
  endtask

  // extra_last: beat that also carries data_last (-1 none); abort_at: beat where rst hits (-1 none)
  task automatic write_burst(input logic [31:0] a, input int n, input logic [31:0] d0,
                             input logic [3:0] strb, input int extra_last, input int abort_at);
    bit aborted = 0;
    handshake(1'b1, a, 4'(n - 1));
    for (int k = 0; k < n && !aborted; k++) begin
      checks++;
      if (resp.data_ok !== 1'b1) begin
        errors++;
        $display("FAIL wr_data_ok beat %0d got %b want 1", k, resp.data_ok);
      end
      req.data_ok = 1'b1; req.data_strobe = strb; req.w_data = d0 + 32'(k);
      req.data_last = (k == n - 1) || (k == extra_last);
      if (k == abort_at) begin
        rst = 1'b1;
        #1;
        checks++;
        if (resp.ready !== 1'b1 || resp.data_ok !== 1'b0 || resp.r_data !== 32'h0) begin
          errors++;
          $display("FAIL abort_reset ready=%b data_ok=%b r_data=%h want 1 0 0",
                   resp.ready, resp.data_ok, resp.r_data);
        end
        @(negedge clk);
        rst = 1'b0;
        aborted = 1;
      end else begin
        model_write(widx(a, k), d0 + 32'(k), strb);
        @(negedge clk);
      end
    end
    req.data_ok = 1'b0; req.data_last = 1'b0; req.data_strobe = 4'h0;
  endtask

  // stall_beat: beat held with req.data_ok low for stall_n cycles (-1 none)
  task automatic read_burst(input logic [31:0] a, input int n, input int stall_beat, input int stall_n);
    int cyc = 1;
    for (int k = 0; k < n; k++)
      exp_q.push_back(model.exists(widx(a, k)) ? model[widx(a, k)] : 32'hx);
    handshake(1'b0, a, 4'(n - 1));
    while (resp.data_ok !== 1'b1 && cyc < 40) begin
      checks++;
      if (resp.r_data !== 32'h0) begin
        errors++;
        $display("FAIL rwait_rdata got %h want 0", resp.r_data);
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != LATENCY + 1) begin
      errors++;
      $display("FAIL read_latency got %0d want %0d", cyc, LATENCY + 1);
    end
    for (int k = 0; k < n; k++) begin
      if (k == stall_beat) begin
        for (int s = 0; s < stall_n; s++) begin
          req.data_ok = 1'b0;
          req.valid = 1'b1; req.write = 1'b1; req.addr = 32'h0000_0F00;
          checks++;
          if (resp.data_ok !== 1'b1 || resp.r_data !== exp_q[0] || resp.ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold beat %0d data_ok=%b r_data=%h ready=%b want 1 %h 0",
                     k, resp.data_ok, resp.r_data, resp.ready, exp_q[0]);
          end
          @(negedge clk);
        end
        req.valid = 1'b0;
      end
      req.data_ok = 1'b1;
      last_rd = resp.r_data;
      checks++;
      if (resp.data_ok !== 1'b1 || resp.r_data !== exp_q[0]) begin
        errors++;
        $display("FAIL read_beat %0d data_ok=%b r_data=%h want 1 %h", k, resp.data_ok, resp.r_data, exp_q[0]);
      end
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    req.data_ok = 1'b0;
    checks++;
    if (resp.ready !== 1'b1 || resp.data_ok !== 1'b0 || resp.r_data !== 32'h0) begin
      errors++;
      $display("FAIL read_end ready=%b data_ok=%b r_data=%h want 1 0 0", resp.ready, resp.data_ok, resp.r_data);
    end
  endtask

  task automatic test_reset();
    req = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (resp.ready !== 1'b1 || resp.data_ok !== 1'b0 || resp.r_data !== 32'h0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state ready=%b data_ok=%b r_data=%h err=%b want 1 0 0 0",
               resp.ready, resp.data_ok, resp.r_data, err);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_burst_read();
    write_burst(32'h400, 4, 32'hA0A0_0000, 4'hF, -1, -1);
    read_burst(32'h400, 4, -1, 0);
  endtask

  task automatic test_stall();
    read_burst(32'h400, 4, 1, 3);
  endtask

  task automatic test_strobe();
    write_burst(32'h20, 1, 32'h1122_3344, 4'hF, -1, -1);
    write_burst(32'h20, 1, 32'hDEAD_BEEF, 4'b0101, -1, -1);
    read_burst(32'h20, 1, -1, 0);
    checks++;
    if (last_rd !== 32'h11AD_33EF) begin
      errors++;
      $display("FAIL strobe_merge got %h want 11ad33ef", last_rd);
    end
    write_burst(32'h20, 1, 32'hFFFF_FFFF, 4'h0, -1, -1);
    read_burst(32'h20, 1, -1, 0);
    checks++;
    if (last_rd !== 32'h11AD_33EF) begin
      errors++;
      $display("FAIL zero_strobe got %h want 11ad33ef", last_rd);
    end
  endtask

  task automatic test_back_to_back();
    write_burst(32'h8, 2, 32'h0808_0000, 4'hF, -1, -1);
    read_burst(32'h8, 1, -1, 0);
    read_burst(32'hC, 1, -1, 0);
    checks++;
    if (last_rd !== 32'h0808_0001) begin
      errors++;
      $display("FAIL b2b_second got %h want 08080001", last_rd);
    end
  endtask

  task automatic test_wrap();
    write_burst(32'h3FFF, 2, 32'h5A5A_0000, 4'hF, -1, -1);
    read_burst(32'h3FFC, 2, -1, 0);
    read_burst(32'h0, 1, -1, 0);
    checks++;
    if (last_rd !== 32'h5A5A_0001) begin
      errors++;
      $display("FAIL wrap_word0 got %h want 5a5a0001", last_rd);
    end
  endtask

  task automatic test_reset_mid_burst();
    write_burst(32'h200, 4, 32'h0101_0000, 4'hF, -1, -1);
    write_burst(32'h200, 4, 32'h0202_0000, 4'hF, -1, 2);
    read_burst(32'h200, 4, -1, 0);
    checks++;
    if (last_rd !== 32'h0101_0003) begin
      errors++;
      $display("FAIL abort_beat3 got %h want 01010003", last_rd);
    end
  endtask

  task automatic test_err();
    logic exp_err;
`ifdef CACHE_BUS_RESP_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clean got %b want 0", err);
    end
    write_burst(32'h300, 4, 32'h0303_0000, 4'hF, 1, -1);
    checks++;
    if (err !== exp_err) begin
      errors++;
      $display("FAIL err_bad_last got %b want %b", err, exp_err);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (err !== exp_err) begin
      errors++;
      $display("FAIL err_sticky got %b want %b", err, exp_err);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_cleared got %b want 0", err);
    end
    read_burst(32'h300, 4, -1, 0);
  endtask

  initial begin
    test_reset();
    test_burst_read();
    test_stall();
    test_strobe();
    test_back_to_back();
    test_wrap();
    test_reset_mid_burst();
    test_err();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
